// File: rtl/lives_manager.sv
// lives_manager
//   Tracks the player's remaining lives for the heart display. A hit in normal play costs
//   one life and opens an invulnerability window of INVULN_FRAMES frame ticks. During that
//   window blink_hide toggles every BLINK_FRAMES ticks so the sprite can blink. Losing the
//   last life enters game-over. A restart pulse reloads MAX_LIVES from any state.
//   All outputs are registered.
//
// Ports
//   clk          in   system clock (pixel clock domain)
//   rst_n        in   asynchronous active-low reset
//   frame_tick   in   one-cycle pulse per video frame
//   hit          in   collision level, sampled every cycle
//   restart      in   one-cycle new-game request (highest priority)
//   lives        out  remaining lives, 0..MAX_LIVES
//   invulnerable out  high during the post-hit window
//   blink_hide   out  sprite-hide phase during the window, 0 otherwise
//   game_over    out  high once the last life is lost
//   life_lost    out  one-cycle pulse per decrement
module lives_manager #(
  parameter int unsigned MAX_LIVES     = 3,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       restart,
  output logic [1:0] lives,
  output logic       invulnerable,
  output logic       blink_hide,
  output logic       game_over,
  output logic       life_lost
);

  localparam int unsigned InvW   = $clog2(INVULN_FRAMES + 1);
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [1:0]      MaxLives = 2'(MAX_LIVES);
  localparam logic [InvW-1:0] InvLoad  = InvW'(INVULN_FRAMES);
  localparam logic [InvW-1:0] InvOne   = InvW'(1);
  // One extra bit so the terminal count BLINK_FRAMES itself is representable.
  localparam logic [BlinkW:0] BlinkEnd = (BlinkW + 1)'(BLINK_FRAMES);

  typedef enum logic [1:0] {
    StPlaying,
    StInvuln,
    StGameOver
  } state_e;

  state_e            r_state;
  logic [1:0]        r_lives;
  logic [InvW-1:0]   r_inv_timer;
  logic [BlinkW-1:0] r_blink_cnt;
  logic              r_invulnerable;
  logic              r_blink_hide;
  logic              r_game_over;
  logic              r_life_lost;

  logic [BlinkW:0]   w_blink_inc;
  logic              w_blink_wrap;

  assign w_blink_inc  = {1'b0, r_blink_cnt} + (BlinkW + 1)'(1);
  assign w_blink_wrap = (w_blink_inc >= BlinkEnd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StPlaying;
      r_lives        <= MaxLives;
      r_inv_timer    <= '0;
      r_blink_cnt    <= '0;
      r_invulnerable <= 1'b0;
      r_blink_hide   <= 1'b0;
      r_game_over    <= 1'b0;
      r_life_lost    <= 1'b0;
    end else begin
      r_life_lost <= 1'b0;
      if (restart) begin
        r_state        <= StPlaying;
        r_lives        <= MaxLives;
        r_inv_timer    <= '0;
        r_blink_cnt    <= '0;
        r_invulnerable <= 1'b0;
        r_blink_hide   <= 1'b0;
        r_game_over    <= 1'b0;
      end else begin
        unique case (r_state)
          StPlaying: begin
            // A tick in the same cycle as the hit is deliberately not counted.
            if (hit) begin
              r_life_lost <= 1'b1;
              if (r_lives <= 2'd1) begin
                r_state     <= StGameOver;
                r_lives     <= 2'd0;
                r_game_over <= 1'b1;
              end else begin
                r_state        <= StInvuln;
                r_lives        <= r_lives - 2'd1;
                r_invulnerable <= 1'b1;
                r_inv_timer    <= InvLoad;
                r_blink_cnt    <= '0;
                r_blink_hide   <= 1'b1;
              end
            end
          end
          StInvuln: begin
            // hit is masked for the whole window.
            if (frame_tick) begin
              if (r_inv_timer <= InvOne) begin
                r_state        <= StPlaying;
                r_invulnerable <= 1'b0;
                r_inv_timer    <= '0;
                r_blink_cnt    <= '0;
                r_blink_hide   <= 1'b0;
              end else begin
                r_inv_timer <= r_inv_timer - InvOne;
                if (w_blink_wrap) begin
                  r_blink_cnt  <= '0;
                  r_blink_hide <= ~r_blink_hide;
                end else begin
                  r_blink_cnt <= w_blink_inc[BlinkW-1:0];
                end
              end
            end
          end
          StGameOver: begin
            r_lives <= 2'd0;
          end
          default: begin
            r_state <= StPlaying;
          end
        endcase
      end
    end
  end

  assign lives        = r_lives;
  assign invulnerable = r_invulnerable;
  assign blink_hide   = r_blink_hide;
  assign game_over    = r_game_over;
  assign life_lost    = r_life_lost;

endmodule
